// File: rtl/piso_tx_arbiter.sv
// piso_tx_arbiter: round-robin arbiter sharing one LSB-first PISO shifter among NREQ word sources.
// Ports: clk/rst (sync, active-high); req_valid/req_data/req_ready per-requester word handshake;
// ser_out/ser_valid/ser_ready serial bit handshake; ser_first/ser_last frame markers;
// grant_id owner of the current frame; busy frame in progress.
module piso_tx_arbiter #(
    parameter int N    = 4,
    parameter int NREQ = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*N-1:0]         req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      ser_out,
    output logic                      ser_valid,
    input  logic                      ser_ready,
    output logic                      ser_first,
    output logic                      ser_last,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy
);
    localparam int GW = $clog2(NREQ);
    localparam int BW = $clog2(N);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state, state_n;
    logic [N-1:0]    shreg, shreg_n;
    logic [BW-1:0]   bcnt, bcnt_n;
    logic [GW-1:0]   ptr, ptr_n, gid_n;
    logic [GW-1:0]   w, w_lo, w_hi;
    logic [NREQ-1:0] hi;
    logic            last, ld;

    // Winner: lowest valid index at or above ptr, else lowest valid index overall (wrap).
    always_comb begin
        hi   = req_valid & ({NREQ{1'b1}} << ptr);
        w_lo = '0;
        w_hi = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) w_lo = GW'(i);
            if (hi[i]) w_hi = GW'(i);
        end
        w = |hi ? w_hi : w_lo;
    end

    assign last      = (state == SHIFT) && (bcnt == BW'(N - 1));
    assign ld        = |req_valid && (state == IDLE || (last && ser_ready));
    assign req_ready = ld ? (NREQ'(1) << w) : '0;
    assign ser_out   = shreg[0];
    assign ser_valid = (state == SHIFT);
    assign busy      = ser_valid;
    assign ser_first = (state == SHIFT) && (bcnt == '0);
    assign ser_last  = last;

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        bcnt_n  = bcnt;
        ptr_n   = ptr;
        gid_n   = grant_id;
        if (ld) begin
            state_n = SHIFT;
            shreg_n = req_data[w*N +: N];
            bcnt_n  = '0;
            gid_n   = w;
            ptr_n   = (w == GW'(NREQ - 1)) ? '0 : w + 1'b1;
        end else if (state == SHIFT && ser_ready) begin
            if (last) begin
                state_n = IDLE;
            end else begin
                shreg_n = {1'b0, shreg[N-1:1]};
                bcnt_n  = bcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bcnt     <= '0;
            ptr      <= '0;
            grant_id <= '0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bcnt     <= bcnt_n;
            ptr      <= ptr_n;
            grant_id <= gid_n;
        end
    end
endmodule

// File: tb/tb_piso_tx_arbiter.sv
// tb_piso_tx_arbiter: directed self-checking bench for piso_tx_arbiter (N=4, NREQ=2).
module tb_piso_tx_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = '0;
    logic [7:0] req_data = '0;
    logic [1:0] req_ready;
    logic       ser_out, ser_valid, ser_first, ser_last, busy;
    logic       ser_ready = 1'b1;
    logic [0:0] grant_id;
    int         passed = 0;
    int         total = 0;

    piso_tx_arbiter #(.N(4), .NREQ(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .ser_out(ser_out), .ser_valid(ser_valid),
        .ser_ready(ser_ready), .ser_first(ser_first), .ser_last(ser_last),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic bitchk(input string tag, input logic o, input logic f, input logic l, input logic g);
        chk({tag, "_valid"}, 32'(ser_valid), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_out"}, 32'(ser_out), 32'(o));
        chk({tag, "_first"}, 32'(ser_first), 32'(f));
        chk({tag, "_last"}, 32'(ser_last), 32'(l));
        chk({tag, "_gid"}, 32'(grant_id), 32'(g));
    endtask

    task automatic idlechk(input string tag);
        chk({tag, "_valid"}, 32'(ser_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_first"}, 32'(ser_first), 32'd0);
        chk({tag, "_last"}, 32'(ser_last), 32'd0);
    endtask

    initial begin
        logic [3:0] word;
        logic       g;
        // Reset values
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        idlechk("rst");
        chk("rst_out", 32'(ser_out), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        // Single request, data0 = 1011 -> 1,1,0,1
        req_valid = 2'b01;
        req_data = 8'h0B;
        #1;
        chk("single_ready", 32'(req_ready), 32'b01);
        @(negedge clk); req_valid = 2'b00; #1;
        bitchk("single_b0", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("single_ready_after", 32'(req_ready), 32'd0);
        @(negedge clk); #1; bitchk("single_b1", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1; bitchk("single_b2", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1; bitchk("single_b3", 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk); #1; idlechk("single_end");
        // Both valid; ptr=1 so grants run 1,0,1,0 back-to-back
        req_valid = 2'b11;
        req_data = 8'h5A;
        #1;
        chk("rr_ready0", 32'(req_ready), 32'b10);
        for (int f = 0; f < 4; f++) begin
            g = (f % 2 == 0);
            word = g ? 4'h5 : 4'hA;
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                if (f == 3 && b == 3) req_valid = 2'b00;
                #1;
                bitchk($sformatf("rr_f%0d_b%0d", f, b), word[b], b == 0, b == 3, g);
                if (b == 3) chk($sformatf("rr_f%0d_ready", f), 32'(req_ready), f == 3 ? 32'd0 : (g ? 32'b01 : 32'b10));
            end
        end
        @(negedge clk); #1; idlechk("rr_end");
        // Stall at bcnt=2: data0 = 0110 -> 0,1,1,0; ptr=1 wraps to requester 0
        req_valid = 2'b01;
        req_data = 8'h56;
        #1;
        chk("st_ready", 32'(req_ready), 32'b01);
        @(negedge clk); req_valid = 2'b00; #1; bitchk("st_b0", 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); #1; bitchk("st_b1", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk); ser_ready = 1'b0; #1; bitchk("st_b2", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1; bitchk("st_hold1", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1; bitchk("st_hold2", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk); ser_ready = 1'b1; #1; bitchk("st_hold3", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk); ser_ready = 1'b0; req_valid = 2'b10; #1;
        bitchk("st_b3", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("st_last_stall_ready", 32'(req_ready), 32'd0);
        @(negedge clk); ser_ready = 1'b1; #1;
        bitchk("st_b3_held", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("st_last_go_ready", 32'(req_ready), 32'b10);
        // Only requester 1 valid: granted repeatedly, data1 = 0101 -> 1,0,1,0
        word = 4'h5;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk); #1;
            bitchk($sformatf("solo_b%0d", b), word[b], b == 0, b == 3, 1'b1);
        end
        chk("solo_regrant", 32'(req_ready), 32'b10);
        @(negedge clk); #1; bitchk("solo2_b0", 1'b1, 1'b1, 1'b0, 1'b1);
        // Reset mid-frame at bit 1
        @(negedge clk); rst = 1'b1; req_valid = 2'b00; req_data = 8'h5B;
        @(negedge clk); rst = 1'b0; #1;
        idlechk("mrst");
        chk("mrst_out", 32'(ser_out), 32'd0);
        chk("mrst_gid", 32'(grant_id), 32'd0);
        chk("mrst_ready", 32'(req_ready), 32'd0);
        req_valid = 2'b11;
        #1;
        chk("mrst_grant", 32'(req_ready), 32'b01);
        // Data change right after accept must not affect the frame (1011)
        @(negedge clk); req_valid = 2'b00; req_data = 8'h50; #1;
        bitchk("dc_b0", 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk); #1; bitchk("dc_b1", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1; bitchk("dc_b2", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1; bitchk("dc_b3", 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk); #1; idlechk("dc_end");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/piso_tx_arbiter.md
# piso_tx_arbiter

Shares one parallel-in/serial-out transmit shifter between `NREQ` word requesters. Round-robin arbitration picks one pending word, loads it, and shifts it out LSB-first, one bit per accepted cycle, under a downstream ready/valid handshake. It sits between the parallel word sources and a single-bit serial link. It owns the shift register, the bit counter and the grant pointer.

## Interface
- `N`, default 4: word width, and the number of serial bits per frame (N ≥ 2).
- `NREQ`, default 2: number of requesters (NREQ ≥ 2).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input NREQ: bit i is high when requester i has a word.
- `req_data` input NREQ*N: requester i word at bits [i*N +: N].
- `req_ready` output NREQ: one-hot or zero. The word from i is accepted in a cycle when `req_valid[i] && req_ready[i]`.
- `ser_out` output 1: current serial bit.
- `ser_valid` output 1: `ser_out` is meaningful.
- `ser_ready` input 1: downstream accepts the bit this cycle.
- `ser_first` output 1: high on bit 0 of a frame.
- `ser_last` output 1: high on bit N-1 of a frame.
- `grant_id` output clog2(NREQ): requester that owns the current frame.
- `busy` output 1: a frame is in progress (equals `ser_valid`).

## Operation
- States:
  - IDLE: no frame in progress.
  - SHIFT: a frame is being sent.
- Internal state:
  - `shreg[N-1:0]`: the shift register.
  - `bcnt`: bit counter, range 0..N-1.
  - `ptr`: round-robin pointer, range 0..NREQ-1.
- Arbitration winner `w`: the first i with `req_valid[i]=1`, scanning from `ptr` upward with wrap-around modulo NREQ.
- Load opportunity `ld`:
  - in IDLE: `ld` = any `req_valid`.
  - in SHIFT: `ld` = `bcnt==N-1 && ser_ready && any req_valid`.
- `req_ready[w]` = `ld` (combinational). All other `req_ready` bits are 0. No requester is ever granted while a frame is in progress except at its last accepted bit.
- On `ld`:
  - `shreg` ← word of w.
  - `bcnt` ← 0.
  - `grant_id` ← w.
  - `ptr` ← (w+1) mod NREQ.
  - state ← SHIFT.
- In SHIFT with `ser_ready=1`:
  - if `bcnt<N-1`: `shreg` ← {1'b0, `shreg[N-1:1]`} and `bcnt` increments.
  - if `bcnt==N-1`: load per `ld` if `ld` holds; otherwise go to IDLE.
- In SHIFT with `ser_ready=0`: hold everything, including `ser_out` and the flags (stall).
- Combinational outputs:
  - `ser_out` = `shreg[0]`.
  - `ser_valid` = `busy` = (state==SHIFT).
  - `ser_first` = SHIFT && `bcnt==0`.
  - `ser_last` = SHIFT && `bcnt==N-1`.
- `ptr` updates only on a grant. A requester that drops `req_valid` before being granted loses nothing: no state is kept per requester.
- The frame is immune to input changes: `req_data` and `req_valid` changes after the load do not affect `shreg`.

## Timing
- Reset values (cycle after `rst` is sampled high):
  - state IDLE; `shreg`=0; `bcnt`=0; `ptr`=0; `grant_id`=0.
  - `ser_out`=0, `ser_valid`=0, `busy`=0, `ser_first`=0, `ser_last`=0, `req_ready`=0.
- `rst` takes priority over everything. Reset mid-frame aborts the frame with no further bits, and the word is lost.
- Latency: a word accepted at edge T presents bit 0 on `ser_out` in the cycle after T.
- Frame length with `ser_ready` held high: exactly N cycles.
- Back-to-back frames:
  - a load at the last bit gives zero idle cycles between frames (`ser_last` is followed directly by `ser_first`).
  - with no pending request at the last bit, `ser_valid` falls the next cycle.
- Stall: while `ser_ready`=0, `req_ready` stays 0, even at `bcnt==N-1`.
- Simultaneous requests: exactly one grant per load. Over consecutive frames with all requesters valid, grants rotate ptr, ptr+1, ….

## Test plan
- Reset then single request (N=4, NREQ=2): `req_valid`=01, data0=4'b1011 → `req_ready`=01 for one cycle; `ser_out`=1,1,0,1 over 4 cycles; `ser_first` on bit 0, `ser_last` on bit 3; `grant_id`=0; then `ser_valid`=0.
- Both requesters always valid: data0=4'hA, data1=4'h5 → grants alternate 0,1,0,1 with no gap cycles; serial stream 0101,1010 repeating (LSB first).
- Stall: `ser_ready` low for 3 cycles at `bcnt`=2 → `ser_out`, `bcnt` and `ser_last` frozen; `req_ready` stays 0; the frame still totals exactly 4 accepted bits.
- Round-robin fairness: after a grant to 1, both valid → next grant is 0. With only requester 1 valid, it is granted repeatedly and `ptr` stays wrapped to 0.
- Reset mid-frame: assert `rst` at bit 1 → next cycle all outputs are at reset values; a new request afterwards is granted to the lowest valid requester from `ptr`=0.
- Data change after accept: alter data0 in the cycle after the grant → the serialized bits match the originally accepted word.
